debounce_bank: RTL and testbench
================================

// Module: debounce_bank
// PURPOSE
//  Parametrised N-channel debouncer for keypad/button inputs. Per channel: input synchroniser and
//  saturating up/down integrator. Outputs a debounced level and one-cycle press/release pulses.
//  Edges are merged into one valid/ready event stream (channel id + press/release) for the keypad
//  decoder/FSM downstream. Replaces per-key single-bit debounce instances.
// PARAMETERS
//  NUM_CH      16     number of independent input channels (>=1)
//  CNT_W       10     integrator width; CNT_MAX = 2**CNT_W-1
//  SYNC_STAGES 2      synchroniser flops per channel (>=1)
//  HOLD_CYC    50000  repeat only: cycles held pressed before first repeat
//  REPEAT_CYC  10000  repeat only: cycles between subsequent repeats
// PORTS
//  clk_i        in   1                single clock, rising edge
//  reset_i      in   1                asynchronous, active-high; clears every flop
//  press_i      in   NUM_CH           raw asynchronous inputs, 1 = pressed
//  state_o      out  NUM_CH           debounced level
//  rise_o       out  NUM_CH           1-cycle pulse, first cycle state_o[c]=1
//  fall_o       out  NUM_CH           1-cycle pulse, first cycle state_o[c]=0
//  rpt_o        out  NUM_CH           1-cycle auto-repeat pulse (0 without macro)
//  evt_v_o      out  1                event valid
//  evt_ready_i  in   1                event accepted when evt_v_o & evt_ready_i
//  evt_ch_o     out  $clog2(NUM_CH)   event channel (min width 1)
//  evt_press_o  out  1                1 = press/repeat, 0 = release
//  evt_rpt_o    out  1                1 = event is an auto-repeat
//  ovf_o        out  1                sticky: pending event overwritten before drain
// BEHAVIOUR
//  Reset (async assert, sync release): synchroniser, cnt, state, pulses, pending, evt_v_o, ovf_o = 0.
//  Sync: s[c] = press_i[c] after SYNC_STAGES flops.
//  Integrator, each edge, s=1:
//   - cnt==CNT_MAX -> state<=1;
//   - else cnt<=cnt+1.
//  Integrator, each edge, s=0:
//   - cnt==0 -> state<=0;
//   - else cnt<=cnt-1.
//  Saturates, never wraps.
//  Latency: press_i steady 1 from idle -> state_o=1 after SYNC_STAGES+CNT_MAX+1 edges.
//   Release is symmetric. Glitches shorter than the current count are absorbed.
//  rise_o/fall_o are registered; assert in the same cycle state_o changes.
//  Pending: per channel one pend bit + type (press/release/repeat), set on rise/fall/rpt.
//  Output reg, loaded when !evt_v_o | evt_ready_i:
//   - takes lowest-index pending channel, clears its pend bit.
//   - no pending -> evt_v_o<=0.
//  evt_* hold stable while evt_v_o & !evt_ready_i.
//  Same-edge load and new edge on that channel: new edge re-sets pend with new type; no ovf.
//  New edge on a channel whose pend=1 (not being loaded): type overwritten, ovf_o<=1 until reset.
//  Throughput: 1 event/cycle with evt_ready_i=1.
//  Reset mid-operation: all in-flight/pending events discarded.
// CONFIGURATION
//  DEBOUNCE_REPEAT_EN defined: per-channel hold counter runs while state_o[c]=1.
//   - rpt_o[c] pulses HOLD_CYC cycles after rise_o[c], then every REPEAT_CYC.
//   - counter cleared on fall.
//   - repeat queued as press event with evt_rpt_o=1.
//  Undefined: no hold counters, rpt_o='0, evt_rpt_o=0, HOLD_CYC/REPEAT_CYC ignored.
// STRUCTURE
//  debounce_pkg: evt_type_e {EVT_RELEASE,EVT_PRESS,EVT_REPEAT}, CH_W function,
//   hold-counter width function of HOLD_CYC/REPEAT_CYC.
//  Sub-module debounce_chan (sync + integrator + pulses + optional repeat), generated NUM_CH times.
//  Top holds pending bits, lowest-index priority pick, event register.
// TESTING (NUM_CH=4, CNT_W=3, SYNC_STAGES=2, HOLD_CYC=20, REPEAT_CYC=5)
//  1. press_i[1] 0->1 held -> state_o[1]=1 and rise_o[1] pulse exactly 10 edges later;
//     evt ch=1 press next cycle.
//  2. press_i[0] 1-cycle glitches every 4 cycles -> state_o[0] stays 0, no events.
//  3. press_i[0],[2] rise same cycle, evt_ready_i=1 -> evt ch=0 then ch=2 on consecutive cycles.
//  4. evt_ready_i=0, ch3 press then release (both debounced) -> ovf_o=1;
//     single evt ch=3 release on ready.
//  5. reset_i asserted mid-count (cnt=5) and with evt_v_o=1 -> all outputs 0 immediately;
//     next press needs full 10 edges.
//  6. DEBOUNCE_REPEAT_EN, hold ch1 -> rpt_o[1] at +20 after rise, then +25, +30;
//     evt_rpt_o=1; none after fall.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the debounce bank.
// The optional auto-repeat feature is enabled by defining DEBOUNCE_REPEAT_EN.
package debounce_pkg;

    typedef enum logic [1:0] {
        EVT_RELEASE = 2'd0,
        EVT_PRESS   = 2'd1,
        EVT_REPEAT  = 2'd2
    } evt_type_e;

    // Channel-id width, never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Hold counter must reach max(HOLD_CYC, REPEAT_CYC) - 1.
    function automatic int hold_w(input int hold_cyc, input int repeat_cyc);
        int m;
        m = (hold_cyc > repeat_cyc) ? hold_cyc : repeat_cyc;
        return (m > 1) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, saturating integrator, edge pulses and,
// when DEBOUNCE_REPEAT_EN is defined, a hold counter producing auto-repeat pulses.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int CNT_W       = 10,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYC    = 50000,
    parameter int REPEAT_CYC  = 10000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic press_i,
    output logic state_o,
    output logic rise_o,
    output logic fall_o,
    output logic rpt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_state;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_s;
    logic                   w_set;
    logic                   w_clr;

    assign w_s   = r_sync[SYNC_STAGES-1];
    assign w_set = w_s & (r_cnt == CNT_MAX) & ~r_state;
    assign w_clr = ~w_s & (r_cnt == '0) & r_state;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= press_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // The level only moves once the integrator is pinned at a rail.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cnt   <= '0;
            r_state <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= w_set;
            r_fall <= w_clr;
            if (w_s) begin
                if (r_cnt == CNT_MAX) r_state <= 1'b1;
                else                  r_cnt   <= r_cnt + 1'b1;
            end else begin
                if (r_cnt == '0) r_state <= 1'b0;
                else             r_cnt   <= r_cnt - 1'b1;
            end
        end
    end

    assign state_o = r_state;
    assign rise_o  = r_rise;
    assign fall_o  = r_fall;

`ifdef DEBOUNCE_REPEAT_EN
    localparam int HW = hold_w(HOLD_CYC, REPEAT_CYC);
    localparam logic [HW-1:0] HOLD_LIM   = HW'(HOLD_CYC - 1);
    localparam logic [HW-1:0] REPEAT_LIM = HW'(REPEAT_CYC - 1);

    logic [HW-1:0] r_hold;
    logic          r_past_first;
    logic          r_rpt;
    logic [HW-1:0] w_lim;

    assign w_lim = r_past_first ? REPEAT_LIM : HOLD_LIM;

    // Counter restarts on every rise; a falling channel never emits a repeat.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_hold       <= '0;
            r_past_first <= 1'b0;
            r_rpt        <= 1'b0;
        end else begin
            r_rpt <= 1'b0;
            if (!r_state || w_clr) begin
                r_hold       <= '0;
                r_past_first <= 1'b0;
            end else if (r_hold == w_lim) begin
                r_rpt        <= 1'b1;
                r_hold       <= '0;
                r_past_first <= 1'b1;
            end else begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    assign rpt_o = r_rpt;
`else
    assign rpt_o = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// N-channel debouncer merging per-channel edges into one valid/ready event stream.
// Define DEBOUNCE_REPEAT_EN to enable auto-repeat pulses and repeat events.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int NUM_CH      = 16,
    parameter int CNT_W       = 10,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYC    = 50000,
    parameter int REPEAT_CYC  = 10000
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [NUM_CH-1:0]         press_i,
    output logic [NUM_CH-1:0]         state_o,
    output logic [NUM_CH-1:0]         rise_o,
    output logic [NUM_CH-1:0]         fall_o,
    output logic [NUM_CH-1:0]         rpt_o,
    output logic                      evt_v_o,
    input  logic                      evt_ready_i,
    output logic [ch_w(NUM_CH)-1:0]   evt_ch_o,
    output logic                      evt_press_o,
    output logic                      evt_rpt_o,
    output logic                      ovf_o
);

    localparam int CHW = ch_w(NUM_CH);

    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_fall;
    logic [NUM_CH-1:0] w_rpt;
    logic [NUM_CH-1:0] w_edge;
    logic [NUM_CH-1:0] w_cand;
    logic [NUM_CH-1:0] w_pick_oh;
    logic [NUM_CH-1:0] w_take;
    evt_type_e         w_new_type [NUM_CH];
    evt_type_e         w_pick_type;
    logic [CHW-1:0]    w_pick;
    logic              w_found;
    logic              w_load;

    logic [NUM_CH-1:0] r_pend;
    evt_type_e         r_ptype [NUM_CH];
    logic              r_evt_v;
    logic [CHW-1:0]    r_evt_ch;
    evt_type_e         r_evt_type;
    logic              r_ovf;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        debounce_chan #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES),
            .HOLD_CYC    (HOLD_CYC),
            .REPEAT_CYC  (REPEAT_CYC)
        ) u_chan (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .press_i (press_i[g]),
            .state_o (state_o[g]),
            .rise_o  (w_rise[g]),
            .fall_o  (w_fall[g]),
            .rpt_o   (w_rpt[g])
        );
    end

    assign rise_o = w_rise;
    assign fall_o = w_fall;
    assign rpt_o  = w_rpt;
    assign w_edge = w_rise | w_fall | w_rpt;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_new_type[c] = EVT_PRESS;
            if (w_fall[c])     w_new_type[c] = EVT_RELEASE;
            else if (w_rpt[c]) w_new_type[c] = EVT_REPEAT;
        end
    end

    // Lowest index wins; a fresh edge on an idle channel bypasses the pending bit.
    always_comb begin
        w_cand      = r_pend | w_edge;
        w_found     = 1'b0;
        w_pick      = '0;
        w_pick_oh   = '0;
        w_pick_type = EVT_RELEASE;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (w_cand[c]) begin
                w_found     = 1'b1;
                w_pick      = CHW'(c);
                w_pick_oh   = '0;
                w_pick_oh[c] = 1'b1;
                w_pick_type = r_pend[c] ? r_ptype[c] : w_new_type[c];
            end
        end
    end

    // Handshake: an event transfers on a rising edge where evt_v_o & evt_ready_i;
    // while evt_v_o is high and evt_ready_i low, evt_* are held unchanged.
    assign w_load = ~r_evt_v | evt_ready_i;
    assign w_take = (w_load && w_found) ? w_pick_oh : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_pend <= '0;
            r_ovf  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_ptype[c] <= EVT_RELEASE;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_take[c]) begin
                    r_pend[c] <= r_pend[c] & w_edge[c];
                    if (w_edge[c]) r_ptype[c] <= w_new_type[c];
                end else if (w_edge[c]) begin
                    r_pend[c]  <= 1'b1;
                    r_ptype[c] <= w_new_type[c];
                end
            end
            if (|(r_pend & w_edge & ~w_take)) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_evt_v    <= 1'b0;
            r_evt_ch   <= '0;
            r_evt_type <= EVT_RELEASE;
        end else if (w_load) begin
            r_evt_v <= w_found;
            if (w_found) begin
                r_evt_ch   <= w_pick;
                r_evt_type <= w_pick_type;
            end
        end
    end

    assign evt_v_o     = r_evt_v;
    assign evt_ch_o    = r_evt_ch;
    assign evt_press_o = (r_evt_type != EVT_RELEASE);
    assign ovf_o       = r_ovf;
`ifdef DEBOUNCE_REPEAT_EN
    assign evt_rpt_o   = (r_evt_type == EVT_REPEAT);
`else
    assign evt_rpt_o   = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank (4 channels, 3-bit integrator).
// Repeat expectations follow DEBOUNCE_REPEAT_EN.
module tb_debounce_bank;

    localparam int NUM_CH      = 4;
    localparam int CNT_W       = 3;
    localparam int SYNC_STAGES = 2;
    localparam int HOLD_CYC    = 20;
    localparam int REPEAT_CYC  = 5;
    localparam int EW          = 4;
`ifdef DEBOUNCE_REPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NUM_CH-1:0] press = '0;
    logic              evt_ready = 1'b1;
    logic [NUM_CH-1:0] state_o;
    logic [NUM_CH-1:0] rise_o;
    logic [NUM_CH-1:0] fall_o;
    logic [NUM_CH-1:0] rpt_o;
    logic              evt_v;
    logic [1:0]        evt_ch;
    logic              evt_press;
    logic              evt_rpt;
    logic              ovf;

    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_q[$];

    debounce_bank #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES),
        .HOLD_CYC    (HOLD_CYC),
        .REPEAT_CYC  (REPEAT_CYC)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .press_i     (press),
        .state_o     (state_o),
        .rise_o      (rise_o),
        .fall_o      (fall_o),
        .rpt_o       (rpt_o),
        .evt_v_o     (evt_v),
        .evt_ready_i (evt_ready),
        .evt_ch_o    (evt_ch),
        .evt_press_o (evt_press),
        .evt_rpt_o   (evt_rpt),
        .ovf_o       (ovf)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] ev(input int ch, input bit is_press, input bit is_rpt);
        logic [1:0] c;
        c = 2'(ch);
        return {c, is_press, is_rpt};
    endfunction

    // Driver tasks: inputs change 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_edge(input int ch, input bit rising, input int max_cyc, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!(rising ? rise_o[ch] : fall_o[ch]) && n < max_cyc);
    endtask

    // Scoreboard: every accepted event must match the oldest expectation.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!reset && evt_v && evt_ready) begin
            if (exp_q.size() == 0) begin
                check("evt_unexpected", 32'({1'b1, evt_ch, evt_press, evt_rpt}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("evt", 32'({evt_ch, evt_press, evt_rpt}), 32'(e));
            end
        end
    end

    initial begin
        int  n;
        bit  seen_high;
        bit  exp_r;

        // Reset state
        #2;
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_evt_v", 32'(evt_v), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: single press, exact latency, event on the following cycle
        press[1] = 1'b1;
        idle(9);
        check("t1_state_early", 32'(state_o[1]), 32'd0);
        step();
        check("t1_state", 32'(state_o[1]), 32'd1);
        check("t1_rise", 32'(rise_o), 32'b0010);
        check("t1_evt_v_early", 32'(evt_v), 32'd0);
        exp_q.push_back(ev(1, 1'b1, 1'b0));
        step();
        check("t1_evt_v", 32'(evt_v), 32'd1);
        check("t1_evt_ch", 32'(evt_ch), 32'd1);
        check("t1_rise_pulse", 32'(rise_o), 32'd0);
        idle(3);
        press[1] = 1'b0;
        wait_edge(1, 1'b0, 20, n);
        check("t1_fall_lat", 32'(n), 32'd10);
        check("t1_state_rel", 32'(state_o[1]), 32'd0);
        exp_q.push_back(ev(1, 1'b0, 1'b0));
        idle(4);

        // 2: short glitches are absorbed
        seen_high = 1'b0;
        for (int i = 0; i < 40; i++) begin
            press[0] = (i % 4 == 0);
            step();
            if (state_o[0]) seen_high = 1'b1;
        end
        press[0] = 1'b0;
        check("t2_glitch", 32'(seen_high), 32'd0);
        idle(12);

        // 3: simultaneous rises drain lowest index first
        press = 4'b0101;
        wait_edge(0, 1'b1, 20, n);
        check("t3_rise_lat", 32'(n), 32'd10);
        check("t3_rise", 32'(rise_o), 32'b0101);
        exp_q.push_back(ev(0, 1'b1, 1'b0));
        exp_q.push_back(ev(2, 1'b1, 1'b0));
        step();
        check("t3_ch_a", 32'(evt_ch), 32'd0);
        step();
        check("t3_v_b", 32'(evt_v), 32'd1);
        check("t3_ch_b", 32'(evt_ch), 32'd2);
        step();
        check("t3_drained", 32'(evt_v), 32'd0);
        press = 4'b0000;
        wait_edge(0, 1'b0, 20, n);
        check("t3_fall", 32'(fall_o), 32'b0101);
        exp_q.push_back(ev(0, 1'b0, 1'b0));
        exp_q.push_back(ev(2, 1'b0, 1'b0));
        idle(4);

        // 4: stalled output, pending overwrite sets overflow
        evt_ready = 1'b0;
        press[0] = 1'b1;
        wait_edge(0, 1'b1, 20, n);
        exp_q.push_back(ev(0, 1'b1, 1'b0));
        step();
        check("t4_hold_v", 32'(evt_v), 32'd1);
        press[3] = 1'b1;
        wait_edge(3, 1'b1, 20, n);
        check("t4_rise3_lat", 32'(n), 32'd10);
        step();
        check("t4_no_ovf", 32'(ovf), 32'd0);
        press[3] = 1'b0;
        wait_edge(3, 1'b0, 20, n);
        exp_q.push_back(ev(3, 1'b0, 1'b0));
        step();
        check("t4_ovf", 32'(ovf), 32'd1);
        check("t4_stable_ch", 32'(evt_ch), 32'd0);
        check("t4_stable_press", 32'(evt_press), 32'd1);
        evt_ready = 1'b1;
        idle(2);
        check("t4_drained", 32'(evt_v), 32'd0);
        check("t4_ovf_sticky", 32'(ovf), 32'd1);
        press[0] = 1'b0;
        wait_edge(0, 1'b0, 20, n);
        exp_q.push_back(ev(0, 1'b0, 1'b0));
        idle(4);

        // 5: reset mid-count and with an event held
        evt_ready = 1'b0;
        press[1] = 1'b1;
        wait_edge(1, 1'b1, 20, n);
        step();
        check("t5_evt_held", 32'(evt_v), 32'd1);
        press[2] = 1'b1;
        idle(7);
        #2;
        reset = 1'b1;
        press = 4'b0100;
        #1;
        check("t5_rst_state", 32'(state_o), 32'd0);
        check("t5_rst_evt_v", 32'(evt_v), 32'd0);
        check("t5_rst_ovf", 32'(ovf), 32'd0);
        check("t5_rst_rise", 32'(rise_o), 32'd0);
        idle(2);
        reset = 1'b0;
        evt_ready = 1'b1;
        idle(9);
        check("t5_state_early", 32'(state_o[2]), 32'd0);
        step();
        check("t5_state", 32'(state_o[2]), 32'd1);
        check("t5_rise", 32'(rise_o), 32'b0100);
        exp_q.push_back(ev(2, 1'b1, 1'b0));
        press[2] = 1'b0;
        wait_edge(2, 1'b0, 20, n);
        exp_q.push_back(ev(2, 1'b0, 1'b0));
        idle(4);

        // 6: hold channel 1, repeat pulses only with the feature enabled
        press[1] = 1'b1;
        wait_edge(1, 1'b1, 20, n);
        check("t6_rise_lat", 32'(n), 32'd10);
        exp_q.push_back(ev(1, 1'b1, 1'b0));
        for (int i = 1; i <= 45; i++) begin
            step();
            if (i == 27) press[1] = 1'b0;
            exp_r = RPT_EN && (i == 20 || i == 25 || i == 30 || i == 35);
            check($sformatf("t6_rpt_%0d", i), 32'(rpt_o[1]), 32'(exp_r));
            check($sformatf("t6_fall_%0d", i), 32'(fall_o[1]), 32'(i == 37));
            if (exp_r) exp_q.push_back(ev(1, 1'b1, 1'b1));
            if (i == 37) exp_q.push_back(ev(1, 1'b0, 1'b0));
        end
        idle(6);

        // Final report
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
